// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with double-buffered image
//
// Purpose: time-multiplexes NDIG digits onto one shared 7-segment bus. Digits advance on
//   scan_tick, separated by BLANK_CYC cycles with every anode off. A shadow buffer is filled
//   by valid/ready and committed to the display image only at a frame boundary. Optional
//   leading-zero suppression.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   scan_tick        1-cycle strobe, advance to the next digit
//   load_valid/ready handshake for load_data/load_dp into the shadow buffer
//   load_data        nibble i = hex code for digit i (digit 0 = rightmost)
//   load_dp          decimal point per digit
//   lz_en            leading-zero suppression enable
//   an, seg, dp      registered display outputs (polarity set by parameters)
//   digit_idx        index of the current/next digit
module seg7_scan_driver #(
  parameter int NDIG           = 4,
  parameter int BLANK_CYC      = 16,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NDIG-1:0]       load_data,
  input  logic [NDIG-1:0]         load_dp,
  input  logic                    lz_en,
  output logic [NDIG-1:0]         an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [$clog2(NDIG)-1:0] digit_idx
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic [NDIG-1:0] AN_OFF = (ACTIVE_LOW_AN != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};
  localparam logic DP_OFF = (ACTIVE_LOW_SEG != 0);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] img_q, img_d, shd_q, shd_d;
  logic [NDIG-1:0]   imgdp_q, imgdp_d, shddp_q, shddp_d;
  logic              ready_q, ready_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              advance, boundary, zero_run;
  logic [NDIG-1:0]   blank_mask, onehot;
  logic [3:0]        code;
  logic [6:0]        pat;

  // Active-high {g,f,e,d,c,b,a} patterns for hex codes
  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;  4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;  4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;  4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;  4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    img_d      = img_q;
    imgdp_d    = imgdp_q;
    shd_d      = shd_q;
    shddp_d    = shddp_q;
    ready_d    = ready_q;
    advance    = 1'b0;
    boundary   = 1'b0;
    zero_run   = 1'b1;
    blank_mask = '0;
    onehot     = '0;
    code       = 4'h0;
    pat        = 7'h00;
    an_d       = AN_OFF;
    seg_d      = SEG_OFF;
    dp_d       = DP_OFF;

    case (state_q)
      IDLE: begin
        if (scan_tick) begin
          state_d  = SHOW;
          idx_d    = '0;
          boundary = 1'b1;
        end
      end
      SHOW: begin
        if (scan_tick) begin
          if (BLANK_CYC == 0) begin
            advance = 1'b1;
          end else begin
            state_d = BLANK;
            cnt_d   = '0;
          end
        end
      end
      BLANK: begin
        // Further scan_ticks are dropped here; only the dead-time counter matters
        if (32'(cnt_q) == BLANK_CYC - 1) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      state_d = SHOW;
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Commit uses the shadow state from before this cycle, so an accept landing on the
    // boundary itself waits for the next frame. Commit and accept are mutually exclusive
    // because accept requires an empty shadow.
    if (boundary && !ready_q) begin
      img_d   = shd_q;
      imgdp_d = shddp_q;
      ready_d = 1'b1;
    end
    if (load_valid && ready_q) begin
      shd_d   = load_data;
      shddp_d = load_dp;
      ready_d = 1'b0;
    end

    // Leading zeros: a digit is blanked if it and every digit above it are zero
    for (int j = NDIG - 1; j >= 1; j--) begin
      zero_run      = zero_run && (img_d[4*j +: 4] == 4'h0);
      blank_mask[j] = zero_run;
    end

    // Outputs are built from next-state values so the registered pins line up with state
    if (state_d == SHOW) begin
      code          = img_d[{idx_d, 2'b00} +: 4];
      pat           = (lz_en && blank_mask[idx_d]) ? 7'h00 : decode(code);
      onehot[idx_d] = 1'b1;
      seg_d         = (ACTIVE_LOW_SEG != 0) ? ~pat : pat;
      an_d          = (ACTIVE_LOW_AN != 0) ? ~onehot : onehot;
      dp_d          = (ACTIVE_LOW_SEG != 0) ? ~imgdp_d[idx_d] : imgdp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      img_q   <= '0;
      imgdp_q <= '0;
      shd_q   <= '0;
      shddp_q <= '0;
      ready_q <= 1'b1;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      img_q   <= img_d;
      imgdp_q <= imgdp_d;
      shd_q   <= shd_d;
      shddp_q <= shddp_d;
      ready_q <= ready_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign load_ready = ready_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_tick = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = 16'h0;
  logic [3:0]  load_dp = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NDIG(4), .BLANK_CYC(2), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
  ) dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_dp(load_dp), .lz_en(lz_en),
    .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                      input logic e_dp, input logic [1:0] e_idx);
    chk({tag, ".an"}, 16'(an), 16'(e_an));
    chk({tag, ".seg"}, 16'(seg), 16'(e_seg));
    chk({tag, ".dp"}, 16'(dp), 16'(e_dp));
    chk({tag, ".idx"}, 16'(digit_idx), 16'(e_idx));
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    load_data  = d;
    load_dp    = p;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    chk("load.ready_low", 16'(load_ready), 16'h0);
  endtask

  // Tick in SHOW, check two dead-time cycles, leave the bench on the first lit cycle
  task automatic tick_blank(input string tag);
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    chk({tag, ".blank1"}, 16'(an), 16'hF);
    step(1);
    chk({tag, ".blank2"}, 16'(an), 16'hF);
    step(1);
  endtask

  initial begin
    // 1. reset state
    step(2);
    rst = 1'b0;
    step(5);
    show("reset", 4'hF, 7'h7F, 1'b1, 2'd0);
    chk("reset.ready", 16'(load_ready), 16'h1);

    // 2. load before first tick; IDLE->SHOW is a frame boundary and commits
    load(16'h1234, 4'h0);
    step(3);
    chk("idle.an", 16'(an), 16'hF);
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    show("d0_4", 4'hE, 7'h19, 1'b1, 2'd0);
    chk("d0_4.ready", 16'(load_ready), 16'h1);
    step(9);

    // 3. latency and a tick during BLANK being ignored
    scan_tick = 1'b1;
    step(1);
    chk("lat.t1.an", 16'(an), 16'hF);
    chk("lat.t1.seg", 16'(seg), 16'h7F);
    step(0);
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    chk("lat.t2.an", 16'(an), 16'hF);
    step(1);
    show("d1_3", 4'hD, 7'h30, 1'b1, 2'd1);
    step(1);
    chk("ignored_tick.an", 16'(an), 16'hD);

    // 4. new load mid-frame waits for the 3->0 boundary
    load(16'h5678, 4'h0);
    step(6);
    tick_blank("to_d2");
    show("d2_old2", 4'hB, 7'h24, 1'b1, 2'd2);
    chk("d2.ready", 16'(load_ready), 16'h0);
    step(9);
    tick_blank("to_d3");
    show("d3_old1", 4'h7, 7'h79, 1'b1, 2'd3);
    chk("d3.ready", 16'(load_ready), 16'h0);
    step(9);
    tick_blank("to_d0");
    show("d0_8", 4'hE, 7'h00, 1'b1, 2'd0);
    chk("d0_8.ready", 16'(load_ready), 16'h1);

    // 5. leading-zero suppression with data 0070; dp on digits 3 and 0
    lz_en = 1'b1;
    load(16'h0070, 4'b1001);
    step(8);
    tick_blank("lz_d1");
    show("lz_pre_d1_7", 4'hD, 7'h78, 1'b1, 2'd1);
    step(5);
    tick_blank("lz_d2");
    show("lz_pre_d2_6", 4'hB, 7'h02, 1'b1, 2'd2);
    step(5);
    tick_blank("lz_d3");
    show("lz_pre_d3_5", 4'h7, 7'h12, 1'b1, 2'd3);
    step(5);
    tick_blank("lz_d0");
    show("lz_d0_0", 4'hE, 7'h40, 1'b0, 2'd0);
    chk("lz.ready", 16'(load_ready), 16'h1);
    step(5);
    tick_blank("lz_d1b");
    show("lz_d1_7", 4'hD, 7'h78, 1'b1, 2'd1);
    step(5);
    tick_blank("lz_d2b");
    show("lz_d2_sup", 4'hB, 7'h7F, 1'b1, 2'd2);
    step(5);
    tick_blank("lz_d3b");
    show("lz_d3_sup", 4'h7, 7'h7F, 1'b0, 2'd3);

    // 6. reset during BLANK with a full shadow discards everything
    lz_en = 1'b0;
    load(16'h9999, 4'h0);
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    chk("rst.pre_blank", 16'(an), 16'hF);
    rst = 1'b1;
    step(1);
    show("rst_mid", 4'hF, 7'h7F, 1'b1, 2'd0);
    chk("rst_mid.ready", 16'(load_ready), 16'h1);
    rst = 1'b0;
    step(2);
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    show("post_rst_d0", 4'hE, 7'h40, 1'b1, 2'd0);
    step(3);
    tick_blank("post_rst_d1");
    show("post_rst_d1", 4'hD, 7'h40, 1'b1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
